// File: rtl/instr_memory_loadable_if.sv
// Fetch and load-port signal bundle for instr_memory_loadable.
// The memory takes the slave side; the fetch stage and boot loader drive the master side.
interface instr_memory_loadable_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
);
   logic              rd_en;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] RD;
   logic              rd_valid;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_err;
   logic              ready;

   modport master (
      output rd_en, A, ld_en, ld_addr, ld_data,
      input  RD, rd_valid, ld_err, ready
   );

   modport slave (
      input  rd_en, A, ld_en, ld_addr, ld_data,
      output RD, rd_valid, ld_err, ready
   );
endinterface

// File: rtl/instr_memory_loadable.sv
// Run-time loadable instruction RAM: filled with a default word after reset, then serves
// registered fetches and accepts load-port writes with range checking.
module instr_memory_loadable #(
   parameter int unsigned       DATA_W        = 32,
   parameter int unsigned       ADDR_W        = 8,
   parameter int unsigned       DEPTH         = 256,
   parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(32'h20070007)
) (
   input logic                    clk,
   input logic                    reset,
   instr_memory_loadable_if.slave bus
);

   localparam int unsigned       IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

   typedef enum logic {StInit, StReady} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ld_err_q, ld_err_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [IdxW-1:0]   mem_widx;
   logic [DATA_W-1:0] mem_wdata;

   logic              rd_in_range;
   logic              ld_in_range;

   // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
   assign rd_in_range = {1'b0, bus.A} < DepthW;
   assign ld_in_range = {1'b0, bus.ld_addr} < DepthW;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      rd_valid_d = 1'b0;
      ld_err_d   = 1'b0;
      mem_we     = 1'b0;
      mem_widx   = cnt_q[IdxW-1:0];
      mem_wdata  = DEFAULT_INSTR;
      if (!reset) begin
         unique case (state_q)
            StInit: begin
               mem_we = 1'b1;
               cnt_d  = cnt_q + ADDR_W'(1);
               if (cnt_q == LastIdx) state_d = StReady;
            end
            StReady: begin
               if (bus.rd_en) begin
                  rd_valid_d = 1'b1;
                  rd_d       = rd_in_range ? mem[bus.A[IdxW-1:0]] : DEFAULT_INSTR;
               end
               if (bus.ld_en) begin
                  if (ld_in_range) begin
                     mem_we    = 1'b1;
                     mem_widx  = bus.ld_addr[IdxW-1:0];
                     mem_wdata = bus.ld_data;
                  end else begin
                     ld_err_d = 1'b1;
                  end
               end
            end
            default: state_d = StInit;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StInit;
         cnt_q      <= '0;
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         ld_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         ld_err_q   <= ld_err_d;
      end
   end

   // Array has no reset; the fetch above reads the pre-edge word (read-before-write).
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_widx] <= mem_wdata;
   end

   assign bus.RD       = rd_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.ld_err   = ld_err_q;
   assign bus.ready    = (state_q == StReady);

endmodule

// File: doc/instr_memory_loadable.md
Name: instr_memory_loadable

Overview:
Parametrised, run-time loadable instruction memory for the single-cycle/multicycle MIPS datapath. It replaces the fixed case-table ROM with a RAM array that is cleared to a default instruction after reset, written through a load port, and read synchronously by the fetch stage. It sits between the PC register and the instruction decoder; the load port is driven by the test/boot loader.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 8, word-address width of A and ld_addr
DEPTH, 256, number of implemented words; legal range 2..2^ADDR_W
DEFAULT_INSTR, 32'h20070007, fill/out-of-range word (ADDi $7, $0, 7)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rd_en  in  1  fetch request, sampled each edge
A  in  ADDR_W  fetch word address
RD  out  DATA_W  fetched instruction, registered
rd_valid  out  1  RD updated by a fetch on the last edge
ld_en  in  1  load-port write strobe
ld_addr  in  ADDR_W  load word address
ld_data  in  DATA_W  load data
ld_err  out  1  one-cycle pulse: load rejected (out of range)
ready  out  1  memory initialised, fetch/load accepted

Behaviour:
- Reset (reset=1 at an edge): state<=INIT, fill counter<=0, RD<=0, rd_valid<=0, ld_err<=0, ready<=0. Array contents not touched on the reset edge itself.
- INIT: each edge with reset=0 writes DEFAULT_INSTR to mem[counter], counter++. The edge that writes entry DEPTH-1 moves to READY and sets ready=1. So ready is first high after the DEPTH-th post-reset edge; 1 write/cycle, no gaps.
- In INIT, rd_en and ld_en are ignored: rd_valid=0, RD holds 0, ld_err=0, no array write.
- READY, fetch: on an edge with rd_en=1, RD<=mem[A] if A<DEPTH, else RD<=DEFAULT_INSTR. rd_valid<=1. Latency 1 cycle. On an edge with rd_en=0, rd_valid<=0 and RD holds its last value.
- READY, load: on an edge with ld_en=1 and ld_addr<DEPTH, mem[ld_addr]<=ld_data, ld_err<=0. If ld_addr>=DEPTH, no write and ld_err<=1 for one cycle. ld_err<=0 on every edge without a rejected load.
- Simultaneous fetch and load to the same address on one edge: read-before-write. RD gets the old word; a fetch on the following edge returns ld_data.
- Fetch and load to different addresses on the same edge are independent and both complete.
- Reset mid-operation (INIT or READY): immediate return to INIT, ready drops on that edge, and the whole array is re-filled. Loaded contents are not preserved.
- Address compare is unsigned over the full ADDR_W bits. When DEPTH=2^ADDR_W, out-of-range never occurs.
- No X on outputs after the first reset edge. The array may be X before the first completed INIT.

Test Plan:
1. Reset 1 cycle, DEPTH=256 -> ready=0 for 255 edges, ready=1 after edge 256. Fetch of A=0x00, 0x7F and 0xFF each returns 0x20070007 with rd_valid=1 one cycle later.
2. Load 0x20010003 @0, 0x20020009 @1, 0x14220002 @2 (ADDi/ADDi/BNE program), then fetch A=0,1,2 back-to-back -> RD=0x20010003, 0x20020009, 0x14220002 on consecutive cycles, rd_valid held 1.
3. Same edge: ld_en @5 with 0x00221824, rd_en A=5 -> RD=0x20070007 (old). Next edge fetch A=5 -> RD=0x00221824.
4. DEPTH=16, ADDR_W=8: load to ld_addr=0x10 -> ld_err=1 for exactly one cycle and no write. Fetch A=0x10 -> RD=0x20070007. Fetch A=0x0F -> default unless loaded.
5. Assert rd_en and ld_en during INIT (cycle 3 after reset) -> rd_valid=0, ld_err=0, RD=0; entry later reads default.
6. Load 0xDEADBEEF @4 in READY, pulse reset, wait for ready -> fetch A=4 returns 0x20070007. ready was low for exactly DEPTH edges.
